// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Widest counter the clamp helper supports.
  localparam int unsigned CLAMP_WIDTH = 32;

  // Clamp a requested load value into the legal range 0..max_count.
  function automatic logic [CLAMP_WIDTH-1:0] clamp_load(
    input logic [CLAMP_WIDTH-1:0] value,
    input logic [CLAMP_WIDTH-1:0] max_count
  );
    return (value > max_count) ? max_count : value;
  endfunction

endpackage

// File: rtl/updown_counter_mod_if.sv
// Control/status bundle between a counter user and updown_counter_mod.
interface updown_counter_mod_if #(
  parameter int unsigned WIDTH = 4
);

  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  modport master (
    output clear, load, load_value, en, up,
    input  count, tc, wrap
  );

  modport slave (
    input  clear, load, load_value, en, up,
    output count, tc, wrap
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the last cycle of each period.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  input  logic en,
  output logic tick
);

  if (PRESCALE <= 1) begin : g_bypass
    // Every enabled cycle is a step; no state needed.
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset_n, restart, en};
    assign tick          = 1'b1;
  end else begin : g_count
    localparam int unsigned PW = $clog2(PRESCALE);

    logic [PW-1:0] phase;

    assign tick = (phase == PW'(PRESCALE - 1));

    // Phase counter: restarts on clear/load, advances only while enabled.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        phase <= '0;
      end else if (restart) begin
        phase <= '0;
      end else if (en) begin
        phase <= tick ? '0 : phase + PW'(1);
      end
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// WIDTH-bit up/down counter with modulus, wrap/saturate, load/clear and prescaler.
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULO   = 16,
  parameter int unsigned WRAP     = 1,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  updown_counter_mod_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             tick;
  logic             restart;
  logic             step;
  logic             at_high;
  logic             at_low;
  logic             at_bound;

  assign restart = bus.clear | bus.load;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart),
    .en      (bus.en),
    .tick    (tick)
  );

  // Bound in the current direction; compared before any +1/-1 so no overflow.
  assign at_high  = (bus.up == CNT_UP)   && (count_q == MAX_COUNT);
  assign at_low   = (bus.up == CNT_DOWN) && (count_q == '0);
  assign at_bound = at_high | at_low;

  // clear and load both pre-empt a step in the same cycle.
  assign step = bus.en & tick & ~restart;

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.tc    = at_bound;

  // Next-state mux: clear > load > step.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = WIDTH'(clamp_load(CLAMP_WIDTH'(bus.load_value), CLAMP_WIDTH'(MAX_COUNT)));
    end else if (step) begin
      wrap_d = at_bound;
      if (at_bound) begin
        if (WRAP != 0) begin
          count_d = (bus.up == CNT_UP) ? '0 : MAX_COUNT;
        end
      end else if (bus.up == CNT_UP) begin
        count_d = count_q + WIDTH'(1);
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench for updown_counter_mod in wrap, saturate and prescaled configs.
module tb_updown_counter_mod;

  typedef struct packed {
    logic [3:0] count;
    logic       tc;
    logic       wrap;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];

  updown_counter_mod_if #(.WIDTH(4)) bus_a ();
  updown_counter_mod_if #(.WIDTH(4)) bus_b ();
  updown_counter_mod_if #(.WIDTH(4)) bus_c ();

  // A: modulo 10 wrapping; B: modulo 10 saturating; C: full range, prescale 3.
  updown_counter_mod #(.WIDTH(4), .MODULO(10), .WRAP(1), .PRESCALE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a));
  updown_counter_mod #(.WIDTH(4), .MODULO(10), .WRAP(0), .PRESCALE(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b));
  updown_counter_mod #(.WIDTH(4), .MODULO(16), .WRAP(1), .PRESCALE(3)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    reset_n = 1'b0;
    repeat (2) tick_clk();
    sb.push_back('{count: 4'd0, tc: 1'b0, wrap: 1'b0});
    e = sb.pop_front();
    n_cmp++;
    if ({bus_a.count, bus_a.tc, bus_a.wrap} !== e) begin
      n_bad++;
      $display("FAIL reset_a: got %h/%b/%b want %h/%b/%b", bus_a.count, bus_a.tc, bus_a.wrap, e.count, e.tc, e.wrap);
    end
    n_cmp++;
    if ({bus_b.count, bus_b.wrap, bus_c.count, bus_c.wrap} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_bc: got b=%h/%b c=%h/%b want 0/0", bus_b.count, bus_b.wrap, bus_c.count, bus_c.wrap);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_up_wrap;
    exp_t e;
    bus_a.up = 1'b1;
    bus_a.en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{count: 4'((i + 1) % 10), tc: ((i + 1) % 10) == 9, wrap: (i == 9)});
      tick_clk();
      e = sb.pop_front();
      n_cmp++;
      if ({bus_a.count, bus_a.tc, bus_a.wrap} !== e) begin
        n_bad++;
        $display("FAIL up_wrap[%0d]: got %h/%b/%b want %h/%b/%b", i, bus_a.count, bus_a.tc, bus_a.wrap, e.count, e.tc, e.wrap);
      end
    end
    bus_a.en = 1'b0;
  endtask

  task automatic test_down_wrap_clamp;
    exp_t e;
    bus_a.up = 1'b0;
    #1;
    n_cmp++;
    if (bus_a.tc !== 1'b1) begin
      n_bad++;
      $display("FAIL tc_down_at_zero: got %b want 1", bus_a.tc);
    end
    bus_a.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: sb.push_back('{count: 4'd9, tc: 1'b0, wrap: 1'b1});
        1: sb.push_back('{count: 4'd8, tc: 1'b0, wrap: 1'b0});
        2: begin
          bus_a.load = 1'b1;
          bus_a.load_value = 4'd12;
          sb.push_back('{count: 4'd9, tc: 1'b0, wrap: 1'b0});
        end
        default: begin
          bus_a.load_value = 4'd3;
          sb.push_back('{count: 4'd3, tc: 1'b0, wrap: 1'b0});
        end
      endcase
      tick_clk();
      e = sb.pop_front();
      n_cmp++;
      if ({bus_a.count, bus_a.tc, bus_a.wrap} !== e) begin
        n_bad++;
        $display("FAIL down_clamp[%0d]: got %h/%b/%b want %h/%b/%b", i, bus_a.count, bus_a.tc, bus_a.wrap, e.count, e.tc, e.wrap);
      end
    end
    bus_a.load = 1'b0;
    bus_a.en = 1'b0;
  endtask

  task automatic test_saturate;
    exp_t e;
    int   prior;
    int   nxt;
    bus_b.up = 1'b1;
    bus_b.en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      nxt = (i + 1 > 9) ? 9 : i + 1;
      sb.push_back('{count: 4'(nxt), tc: (nxt == 9), wrap: (i >= 9)});
      tick_clk();
      e = sb.pop_front();
      n_cmp++;
      if ({bus_b.count, bus_b.tc, bus_b.wrap} !== e) begin
        n_bad++;
        $display("FAIL sat_up[%0d]: got %h/%b/%b want %h/%b/%b", i, bus_b.count, bus_b.tc, bus_b.wrap, e.count, e.tc, e.wrap);
      end
    end
    bus_b.up = 1'b0;
    for (int i = 0; i < 11; i++) begin
      prior = (i > 9) ? 0 : 9 - i;
      nxt = (prior > 0) ? prior - 1 : 0;
      sb.push_back('{count: 4'(nxt), tc: (nxt == 0), wrap: (prior == 0)});
      tick_clk();
      e = sb.pop_front();
      n_cmp++;
      if ({bus_b.count, bus_b.tc, bus_b.wrap} !== e) begin
        n_bad++;
        $display("FAIL sat_down[%0d]: got %h/%b/%b want %h/%b/%b", i, bus_b.count, bus_b.tc, bus_b.wrap, e.count, e.tc, e.wrap);
      end
    end
    bus_b.en = 1'b0;
  endtask

  task automatic test_prescale;
    exp_t e;
    int   pre;
    int   cnt;
    logic wrap_e;
    pre = 0;
    cnt = 0;
    bus_c.up = 1'b1;
    for (int cyc = 0; cyc < 54; cyc++) begin
      bus_c.en = !(cyc == 10 || cyc == 11);
      wrap_e = 1'b0;
      if (bus_c.en) begin
        if (pre == 2) begin
          pre = 0;
          wrap_e = (cnt == 15);
          cnt = (cnt + 1) % 16;
        end else begin
          pre++;
        end
      end
      sb.push_back('{count: 4'(cnt), tc: (cnt == 15), wrap: wrap_e});
      tick_clk();
      e = sb.pop_front();
      n_cmp++;
      if ({bus_c.count, bus_c.tc, bus_c.wrap} !== e) begin
        n_bad++;
        $display("FAIL prescale[%0d]: got %h/%b/%b want %h/%b/%b", cyc, bus_c.count, bus_c.tc, bus_c.wrap, e.count, e.tc, e.wrap);
      end
    end
    bus_c.en = 1'b0;
  endtask

  task automatic test_clear_load;
    exp_t e;
    bus_a.up = 1'b1;
    bus_a.en = 1'b1;
    bus_a.load_value = 4'd5;
    for (int i = 0; i < 3; i++) begin
      bus_a.clear = (i == 0);
      bus_a.load  = (i < 2);
      case (i)
        0: sb.push_back('{count: 4'd0, tc: 1'b0, wrap: 1'b0});
        1: sb.push_back('{count: 4'd5, tc: 1'b0, wrap: 1'b0});
        default: sb.push_back('{count: 4'd6, tc: 1'b0, wrap: 1'b0});
      endcase
      tick_clk();
      e = sb.pop_front();
      n_cmp++;
      if ({bus_a.count, bus_a.tc, bus_a.wrap} !== e) begin
        n_bad++;
        $display("FAIL clear_load[%0d]: got %h/%b/%b want %h/%b/%b", i, bus_a.count, bus_a.tc, bus_a.wrap, e.count, e.tc, e.wrap);
      end
    end
    bus_a.clear = 1'b0;
    bus_a.load = 1'b0;
    bus_a.en = 1'b0;
  endtask

  task automatic test_async_reset;
    exp_t e;
    bus_a.load = 1'b1;
    bus_a.load_value = 4'd7;
    sb.push_back('{count: 4'd7, tc: 1'b0, wrap: 1'b0});
    tick_clk();
    bus_a.load = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if ({bus_a.count, bus_a.tc, bus_a.wrap} !== e) begin
      n_bad++;
      $display("FAIL preload7: got %h/%b/%b want %h/%b/%b", bus_a.count, bus_a.tc, bus_a.wrap, e.count, e.tc, e.wrap);
    end
    #3;
    reset_n = 1'b0;
    sb.push_back('{count: 4'd0, tc: 1'b0, wrap: 1'b0});
    #1;
    e = sb.pop_front();
    n_cmp++;
    if ({bus_a.count, bus_a.tc, bus_a.wrap} !== e) begin
      n_bad++;
      $display("FAIL async_reset_a: got %h/%b/%b want %h/%b/%b", bus_a.count, bus_a.tc, bus_a.wrap, e.count, e.tc, e.wrap);
    end
    n_cmp++;
    if (bus_c.count !== 4'd0) begin
      n_bad++;
      $display("FAIL async_reset_c: got %h want 0", bus_c.count);
    end
    #2;
    reset_n = 1'b1;
    sb.push_back('{count: 4'd0, tc: 1'b0, wrap: 1'b0});
    tick_clk();
    e = sb.pop_front();
    n_cmp++;
    if ({bus_a.count, bus_a.tc, bus_a.wrap} !== e) begin
      n_bad++;
      $display("FAIL post_reset_hold: got %h/%b/%b want %h/%b/%b", bus_a.count, bus_a.tc, bus_a.wrap, e.count, e.tc, e.wrap);
    end
  endtask

  // Bounded run time in case the DUT stalls the clocked sequence.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    bus_a.clear = 1'b0; bus_a.load = 1'b0; bus_a.load_value = '0; bus_a.en = 1'b0; bus_a.up = 1'b1;
    bus_b.clear = 1'b0; bus_b.load = 1'b0; bus_b.load_value = '0; bus_b.en = 1'b0; bus_b.up = 1'b1;
    bus_c.clear = 1'b0; bus_c.load = 1'b0; bus_c.load_value = '0; bus_c.en = 1'b0; bus_c.up = 1'b1;
    test_reset();
    test_up_wrap();
    test_down_wrap_clamp();
    test_saturate();
    test_prescale();
    test_clear_load();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
